// File: rtl/base_mul.sv
// base_mul - iterative 33x33 signed Booth multiplier (low 64 bits of product)
//
// Callers extend 32-bit operands to 33 bits (sign-extend for signed, zero-extend
// for unsigned). One Booth digit is retired per clock; the product is latched
// into `result` on the edge entering DONE and held until the next completion.
//
// Ports:
//   mul_clk    in   1   clock, rising edge
//   resetn     in   1   synchronous active-low reset
//   in_valid   in   1   operands present on src1/src2
//   in_ready   out  1   unit accepts operands this cycle (0 while resetn=0)
//   src1       in  33   multiplier, two's complement
//   src2       in  33   multiplicand, two's complement
//   out_valid  out  1   one-cycle pulse, result valid
//   result     out 64   product, two's complement
//
// Configuration macro: BASE_MUL_RADIX4_EN
//   undefined : radix-2 Booth, 33 iterations, 34-cycle acceptance-to-valid
//   defined   : radix-4 Booth, 17 iterations, 18-cycle acceptance-to-valid
//
// state  | meaning
// -------+-----------------------------------------------------
// S_IDLE | waiting for operands, in_ready=1
// S_BUSY | iterating Booth digits, in_ready=0
// S_DONE | result valid for one cycle, can accept next operands

module base_mul (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] src1,
  input  logic [32:0] src2,
  output logic        out_valid,
  output logic [63:0] result
);

`ifdef BASE_MUL_RADIX4_EN
  localparam int QW   = 34;  // multiplier sign-extended to an even width
  localparam int AW   = 35;  // room for +/-2M without overflow
  localparam int ITER = 17;
`else
  localparam int QW   = 33;
  localparam int AW   = 34;
  localparam int ITER = 33;
`endif

  localparam logic [5:0] CNT_INIT = 6'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_acc;
  logic [QW-1:0]   r_mplr;
  logic            r_qm1;
  logic [32:0]     r_mcand;
  logic [5:0]      r_cnt;

  logic            w_accept;
  logic            w_last;
  logic [AW-1:0]   w_m;
  logic [AW-1:0]   w_sum;
  logic [AW-1:0]   w_acc_nxt;
  logic [QW-1:0]   w_mplr_nxt;
  logic            w_qm1_nxt;
  logic [QW-1:0]   w_mplr_load;

  assign in_ready  = resetn && (r_state != S_BUSY);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == S_BUSY) && (r_cnt == 6'd0);
  assign w_m       = {{(AW-33){r_mcand[32]}}, r_mcand};

`ifdef BASE_MUL_RADIX4_EN
  logic [AW-1:0] w_m2;
  assign w_m2        = {w_m[AW-2:0], 1'b0};
  assign w_mplr_load = {src1[32], src1};

  // digit = -2*b[2i+1] + b[2i] + b[2i-1]
  always_comb begin
    w_sum = r_acc;
    case ({r_mplr[1:0], r_qm1})
      3'b001, 3'b010: w_sum = r_acc + w_m;
      3'b011:         w_sum = r_acc + w_m2;
      3'b100:         w_sum = r_acc - w_m2;
      3'b101, 3'b110: w_sum = r_acc - w_m;
      default:        w_sum = r_acc;
    endcase
  end

  // arithmetic shift of {acc, mplr, qm1} by two
  assign w_acc_nxt  = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_mplr_nxt = {w_sum[1:0], r_mplr[QW-1:2]};
  assign w_qm1_nxt  = r_mplr[1];
`else
  assign w_mplr_load = src1;

  always_comb begin
    w_sum = r_acc;
    case ({r_mplr[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m;
      2'b10:   w_sum = r_acc - w_m;
      default: w_sum = r_acc;
    endcase
  end

  // arithmetic shift of {acc, mplr, qm1} by one
  assign w_acc_nxt  = {w_sum[AW-1], w_sum[AW-1:1]};
  assign w_mplr_nxt = {w_sum[0], r_mplr[QW-1:1]};
  assign w_qm1_nxt  = r_mplr[0];
`endif

  always_ff @(posedge mul_clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? S_BUSY : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Once all digits are retired, the full product sits in {acc, mplr};
  // its low 64 bits are taken straight from the shifted next value.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      r_acc   <= '0;
      r_mplr  <= '0;
      r_qm1   <= 1'b0;
      r_mcand <= '0;
      r_cnt   <= '0;
      result  <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_mplr  <= w_mplr_load;
      r_qm1   <= 1'b0;
      r_mcand <= src2;
      r_cnt   <= CNT_INIT;
    end else if (r_state == S_BUSY) begin
      r_acc  <= w_acc_nxt;
      r_mplr <= w_mplr_nxt;
      r_qm1  <= w_qm1_nxt;
      if (w_last) result <= {w_acc_nxt[63-QW:0], w_mplr_nxt};
      else        r_cnt  <= r_cnt - 6'd1;
    end
  end

endmodule

// File: tb/tb_base_mul.sv
module tb_base_mul;

`ifdef BASE_MUL_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        mul_clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] src1;
  logic [32:0] src2;
  logic        out_valid;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  base_mul dut (
    .mul_clk  (mul_clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .src1     (src1),
    .src2     (src2),
    .out_valid(out_valid),
    .result   (result)
  );

  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  typedef struct {
    logic [32:0] a;
    logic [32:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: signed product of the two 33-bit values, truncated to 64 bits.
  function automatic logic [63:0] model(input logic [32:0] a, input logic [32:0] b);
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    return p[63:0];
  endfunction

  function automatic logic [32:0] rext();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(0, 1) == 1) return {x[31], x};
    return {1'b0, x};
  endfunction

  task automatic run_op(input logic [32:0] a, input logic [32:0] b,
                        input logic [63:0] exp, input string nm);
    int waited;
    int lat;
    waited = 0;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    in_valid = 1'b1;
    src1 = a;
    src2 = b;
    tick();
    in_valid = 1'b0;
    src1 = rext();
    src2 = rext();
    lat = 0;
    while (!out_valid && lat < 200) begin
      src1 = rext();
      src2 = rext();
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(LAT));
    chk({nm, "_result"}, result, exp);
    tick();
    chk({nm, "_pulse"}, {63'd0, out_valid}, 64'd0);
    chk({nm, "_hold"}, result, exp);
  endtask

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] e;
    int          cyc;
    int          last_ov;
    int          n_res;
    int          n_ov;

    vecs[0] = '{33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{33'h1_FFFFFFFF, 33'h1_FFFFFFFF, 64'h0000000000000001};
    vecs[2] = '{33'h1_80000000, 33'h1_80000000, 64'h4000000000000000};
    vecs[3] = '{33'h1_80000000, 33'h0_7FFFFFFF, 64'hC000000080000000};
    vecs[4] = '{33'h0_00000007, 33'h1_FFFFFFFD, 64'hFFFFFFFFFFFFFFEB};
    vecs[5] = '{33'h0_00000000, 33'h1_23456789, 64'h0000000000000000};
    vecs[6] = '{33'h0_00000002, 33'h0_00000003, 64'h0000000000000006};
    vecs[7] = '{33'h1_00000000, 33'h1_00000000, 64'h0000000000000000};

    // reset held with in_valid high
    resetn   = 1'b0;
    in_valid = 1'b1;
    src1     = 33'h0_00000005;
    src2     = 33'h0_00000005;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    resetn = 1'b1;
    #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("rel_accepted", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    n_ov = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      if (out_valid) n_ov++;
    end
    chk("rel_first_valid_count", 64'(n_ov), 64'd1);

    // directed table
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // back-to-back with operands changing every cycle
    exp_q.delete();
    last_ov  = -1;
    n_res    = 0;
    cyc      = 0;
    in_valid = 1'b1;
    while (n_res < 6 && cyc < 6 * (LAT + 1) + 50) begin
      src1 = rext();
      src2 = rext();
      if (in_ready) exp_q.push_back(model(src1, src2));
      tick();
      cyc++;
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~result;
        chk($sformatf("b2b%0d_result", n_res), result, e);
        if (last_ov >= 0) chk($sformatf("b2b%0d_period", n_res), 64'(cyc - last_ov), 64'(LAT + 1));
        last_ov = cyc;
        n_res++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 64'(n_res), 64'd6);
    tick();

    // reset in the middle of an operation
    in_valid = 1'b1;
    src1 = 33'h0_12345678;
    src2 = 33'h0_0000ABCD;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    resetn = 1'b0;
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("midrst_result", result, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    resetn = 1'b1;
    n_ov = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      tick();
      if (out_valid) n_ov++;
    end
    chk("midrst_no_valid", 64'(n_ov), 64'd0);
    run_op(33'h0_00000007, 33'h1_FFFFFFFD, 64'hFFFFFFFFFFFFFFEB, "midrst_next");

    // random regression
    for (int i = 0; i < 400; i++) begin
      logic [32:0] a;
      logic [32:0] b;
      a = rext();
      b = rext();
      run_op(a, b, model(a, b), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
